alu_ctrl_decoder: RTL

- Pipelined decoder that produces the 3-bit ALU control code (and an illegal flag) from a 32-bit RV32I instruction.
- Drives the control input of the datapath ALU in the registered decode/execute split of the core.
- Valid/ready handshake on both sides; 2-entry skid buffer so in_ready is a registered signal; 1-cycle latency.

---
 rtl/alu_ctrl_decoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - pipelined RV32I ALU control decoder with 2-entry skid buffer
//
// Purpose: decodes a 32-bit RV32I instruction into a 3-bit ALU control code plus an
// illegal flag, one cycle after acceptance, behind a valid/ready handshake on both sides.
// Storage is an output register plus one skid register, so in_ready is registered.
//
// Ports:
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   in_valid, in_ready         input handshake (in_ready = !skid_full, registered)
//   in_instr[31:0]             instruction word
//   out_valid, out_ready       output handshake
//   out_alu_control[2:0]       000 ADD, 001 SLL, 010 SUB, 100 XOR, 101 SRL, 110 OR, 111 AND
//   out_illegal                instruction not executable by the ALU (ctrl = ILLEGAL_CTRL)
//   out_instr[31:0]            decoded instruction passed through (0 when PASS_INSTR=0)
//
// Optional feature macro: ALU_DEC_SLT_EN - decode SLT/SLTI to code 011.
module alu_ctrl_decoder #(
  parameter logic [2:0] ILLEGAL_CTRL = 3'b000,
  parameter bit         PASS_INSTR   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_alu_control,
  output logic        out_illegal,
  output logic [31:0] out_instr
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       f7_alt;
  logic [2:0] raw_ctrl;
  logic       raw_ok;
  logic [2:0] dec_ctrl;
  logic       dec_illegal;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  always_comb begin
    raw_ok   = 1'b0;
    raw_ctrl = ALU_ADD;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: begin
          case (funct3)
            3'b000: begin
              if (f7_zero) begin raw_ok = 1'b1; raw_ctrl = ALU_ADD; end
              else if (f7_alt) begin raw_ok = 1'b1; raw_ctrl = ALU_SUB; end
            end
            3'b001: begin raw_ok = f7_zero; raw_ctrl = ALU_SLL; end
`ifdef ALU_DEC_SLT_EN
            3'b010: begin raw_ok = f7_zero; raw_ctrl = ALU_SLT; end
`endif
            3'b100: begin raw_ok = f7_zero; raw_ctrl = ALU_XOR; end
            // SRA (funct7 0100000) is deliberately rejected: no arithmetic shifter.
            3'b101: begin raw_ok = f7_zero; raw_ctrl = ALU_SRL; end
            3'b110: begin raw_ok = f7_zero; raw_ctrl = ALU_OR;  end
            3'b111: begin raw_ok = f7_zero; raw_ctrl = ALU_AND; end
            default: raw_ok = 1'b0;
          endcase
        end
        7'b0010011: begin
          // For shift immediates funct7 occupies imm[11:5].
          case (funct3)
            3'b000: begin raw_ok = 1'b1;    raw_ctrl = ALU_ADD; end
            3'b001: begin raw_ok = f7_zero; raw_ctrl = ALU_SLL; end
`ifdef ALU_DEC_SLT_EN
            3'b010: begin raw_ok = 1'b1;    raw_ctrl = ALU_SLT; end
`endif
            3'b100: begin raw_ok = 1'b1;    raw_ctrl = ALU_XOR; end
            3'b101: begin raw_ok = f7_zero; raw_ctrl = ALU_SRL; end
            3'b110: begin raw_ok = 1'b1;    raw_ctrl = ALU_OR;  end
            3'b111: begin raw_ok = 1'b1;    raw_ctrl = ALU_AND; end
            default: raw_ok = 1'b0;
          endcase
        end
        // Address / PC arithmetic all uses the adder.
        7'b0000011, 7'b0100011, 7'b1100111,
        7'b0110111, 7'b0010111, 7'b1101111: begin
          raw_ok   = 1'b1;
          raw_ctrl = ALU_ADD;
        end
        // Branches compare via subtraction; f3 010/011 are not defined branches.
        7'b1100011: begin
          raw_ok   = (funct3 != 3'b010) && (funct3 != 3'b011);
          raw_ctrl = ALU_SUB;
        end
        default: raw_ok = 1'b0;
      endcase
    end
    dec_illegal = !raw_ok;
    dec_ctrl    = raw_ok ? raw_ctrl : ILLEGAL_CTRL;
  end

  logic       in_ready_q;
  logic       out_valid_q;
  logic [2:0] out_ctrl_q;
  logic       out_illegal_q;
  logic       skid_full;
  logic [2:0] skid_ctrl;
  logic       skid_illegal;

  logic in_xfer;
  logic out_free;
  logic load_out_skid;
  logic load_out_in;
  logic load_skid;
  logic skid_full_next;

  assign in_xfer  = in_valid && in_ready_q;
  // Output register can take new data if it is empty or being consumed this cycle.
  assign out_free = !out_valid_q || out_ready;
  // in_ready is low whenever the skid is full, so in_xfer never coincides with it.
  assign load_out_skid = out_free && skid_full;
  assign load_out_in   = out_free && !skid_full && in_xfer;
  assign load_skid     = !out_free && in_xfer;

  always_comb begin
    skid_full_next = skid_full;
    if (load_out_skid)  skid_full_next = 1'b0;
    else if (load_skid) skid_full_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_ctrl_q    <= 3'b000;
      out_illegal_q <= 1'b0;
      skid_full     <= 1'b0;
      skid_ctrl     <= 3'b000;
      skid_illegal  <= 1'b0;
    end else begin
      in_ready_q <= !skid_full_next;
      skid_full  <= skid_full_next;
      if (out_free) out_valid_q <= skid_full || in_xfer;
      if (load_out_skid) begin
        out_ctrl_q    <= skid_ctrl;
        out_illegal_q <= skid_illegal;
      end else if (load_out_in) begin
        out_ctrl_q    <= dec_ctrl;
        out_illegal_q <= dec_illegal;
      end
      if (load_skid) begin
        skid_ctrl    <= dec_ctrl;
        skid_illegal <= dec_illegal;
      end
    end
  end

  generate
    if (PASS_INSTR) begin : g_pass_instr
      logic [31:0] out_instr_q;
      logic [31:0] skid_instr_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_instr_q  <= 32'h0;
          skid_instr_q <= 32'h0;
        end else begin
          if (load_out_skid)    out_instr_q <= skid_instr_q;
          else if (load_out_in) out_instr_q <= in_instr;
          if (load_skid) skid_instr_q <= in_instr;
        end
      end
      assign out_instr = out_instr_q;
    end else begin : g_no_instr
      assign out_instr = 32'h0;
    end
  endgenerate

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_alu_control = out_ctrl_q;
  assign out_illegal     = out_illegal_q;

endmodule
